// File: rtl/bird_gfx_pkg.sv
// Shared graphics constants and the renderer state encoding.
package bird_gfx_pkg;

    localparam logic [2:0] BLACK          = 3'b000;
    localparam logic [2:0] GREEN          = 3'b010;
    localparam logic [7:0] BIRD_X_DEFAULT = 8'd20;
    localparam int         SCREEN_W       = 160;
    localparam int         SCREEN_H       = 120;
    localparam int         SPRITE_DIM     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sprite_pixel_scanner.sv
// Walks the 16 pixels of a 4x4 sprite in raster order and produces the
// screen coordinate of the current pixel plus a vertical clip flag.
module sprite_pixel_scanner
    import bird_gfx_pkg::*;
#(
    parameter logic [7:0] BIRD_X = BIRD_X_DEFAULT,
    parameter int         HEIGHT = SCREEN_H
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       step,
    input  logic [6:0] base_y,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       in_bounds,
    output logic       last
);

    localparam logic [7:0] HEIGHT_8 = 8'(HEIGHT);

    logic [3:0] pix_cnt;
    logic [7:0] y_full;

    // Pixel counter; clear takes priority so a phase change restarts at 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pix_cnt <= 4'd0;
        end else if (clear) begin
            pix_cnt <= 4'd0;
        end else if (step) begin
            pix_cnt <= pix_cnt + 4'd1;
        end
    end

    // Coordinate decode: 8-bit row sum so rows past the bottom edge are
    // detected rather than wrapping back to the top of the screen.
    always_comb begin
        x         = BIRD_X + {6'd0, pix_cnt[1:0]};
        y_full    = {1'b0, base_y} + {6'd0, pix_cnt[3:2]};
        y         = y_full[6:0];
        in_bounds = (y_full < HEIGHT_8);
        last      = (pix_cnt == 4'hF);
    end

endmodule

// File: rtl/bird_sprite_renderer.sv
// Accepts a new bird y, erases the previously drawn sprite and draws the
// new one, producing a one-pixel-per-cycle write stream for the VGA adapter.
module bird_sprite_renderer
    import bird_gfx_pkg::state_t;
    import bird_gfx_pkg::IDLE;
    import bird_gfx_pkg::ERASE;
    import bird_gfx_pkg::DRAW;
    import bird_gfx_pkg::DONE;
#(
    parameter logic [7:0] BIRD_X       = bird_gfx_pkg::BIRD_X_DEFAULT,
    parameter int         SCREEN_H     = bird_gfx_pkg::SCREEN_H,
    parameter logic [2:0] DRAW_COLOUR  = bird_gfx_pkg::GREEN,
    parameter logic [2:0] ERASE_COLOUR = bird_gfx_pkg::BLACK
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pos_valid,
    input  logic [6:0] pos_y,
    output logic       pos_ready,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       done,
    output logic [1:0] state_dbg
);

    // Handshake: a position transfers on a clk edge where pos_valid and
    // pos_ready are both high; pos_ready is high only in IDLE, the producer
    // holds pos_valid and pos_y stable until that edge, and pos_y is ignored
    // at every other time.

    state_t     state, next_state;
    logic [6:0] old_y, new_y;
    logic       have_old;
    logic       accept;
    logic       scan_clear, scan_step;
    logic [6:0] base_y;
    logic       in_bounds, last;

    sprite_pixel_scanner #(
        .BIRD_X (BIRD_X),
        .HEIGHT (SCREEN_H)
    ) u_scanner (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (scan_clear),
        .step      (scan_step),
        .base_y    (base_y),
        .x         (vga_x),
        .y         (vga_y),
        .in_bounds (in_bounds),
        .last      (last)
    );

    assign accept    = (state == IDLE) && pos_valid;
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Position registers: capture on acceptance, retire to old_y once drawn.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            new_y    <= 7'd0;
            old_y    <= 7'd0;
            have_old <= 1'b0;
        end else begin
            if (accept) begin
                new_y <= pos_y;
            end
            if (state == DONE) begin
                old_y    <= new_y;
                have_old <= 1'b1;
            end
        end
    end

    // Next-state and output decode; erase always precedes draw when a
    // sprite is on screen, even if the y value did not change.
    always_comb begin
        next_state = state;
        pos_ready  = 1'b0;
        vga_plot   = 1'b0;
        done       = 1'b0;
        vga_colour = ERASE_COLOUR;
        base_y     = new_y;
        scan_clear = 1'b0;
        scan_step  = 1'b0;
        case (state)
            IDLE: begin
                pos_ready = 1'b1;
                if (pos_valid) begin
                    scan_clear = 1'b1;
                    next_state = have_old ? ERASE : DRAW;
                end
            end
            ERASE: begin
                base_y    = old_y;
                vga_plot  = in_bounds;
                scan_step = 1'b1;
                if (last) begin
                    scan_clear = 1'b1;
                    next_state = DRAW;
                end
            end
            DRAW: begin
                vga_colour = DRAW_COLOUR;
                vga_plot   = in_bounds;
                scan_step  = 1'b1;
                if (last) begin
                    scan_clear = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule
